// File: rtl/counter_bcd_display_pkg.sv
// Shared definitions for the BCD display counter: width helper and 7-segment encodings.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package counter_bcd_display_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/counter_bcd_display_digit.sv
// One BCD digit of the up/down ripple chain; step_out is the carry (up) or borrow (down).
module bcd_digit_updown (
  input  logic       clk,
  input  logic       aclr,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       step_out
);

  logic [3:0] digit_reg;
  logic [3:0] digit_next;

  always_comb begin
    digit_next = digit_reg;
    if (load) begin
      digit_next = (load_digit > 4'd9) ? 4'd9 : load_digit;
    end else if (step_in) begin
      if (up) begin
        digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end else begin
        digit_next = (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      digit_reg <= 4'd0;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign digit    = digit_reg;
  assign step_out = step_in & (up ? (digit_reg == 4'd9) : (digit_reg == 4'd0));

endmodule

// File: rtl/counter_bcd_display.sv
// Prescaled BCD up/down counter with load, wrap/tick pulses and 7-segment outputs.
module counter_bcd_display
  import counter_bcd_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10000000,
  parameter int LZB      = 0
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  tick,
  output logic                  wrap
);

  localparam int              PW      = (clog2(PRESCALE) > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] prescale_reg;
  logic [PW-1:0] prescale_next;
  logic          tick_reg;
  logic          wrap_reg;
  logic          step;

  // Load wins over a coincident step, so the step is suppressed here rather than in each digit.
  assign step = enable && (prescale_reg == PRE_MAX) && !load;

  always_comb begin
    prescale_next = prescale_reg;
    if (load) begin
      prescale_next = '0;
    end else if (enable) begin
      prescale_next = (prescale_reg == PRE_MAX) ? '0 : prescale_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      prescale_reg <= '0;
      tick_reg     <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      prescale_reg <= prescale_next;
      tick_reg     <= step;
      wrap_reg     <= g_digit[DIGITS-1].step_out;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic       step_in;
      logic       step_out;
      logic [3:0] digit;
      logic       zero_above;

      if (gi == 0) begin : g_first
        assign step_in = step;
      end else begin : g_chain
        assign step_in = g_digit[gi-1].step_out;
      end

      // zero_above: every more-significant digit is zero, so a zero here is a leading zero.
      if (gi == DIGITS - 1) begin : g_top
        assign zero_above = 1'b1;
      end else begin : g_lower
        assign zero_above = g_digit[gi+1].zero_above && (g_digit[gi+1].digit == 4'd0);
      end

      bcd_digit_updown u_digit (
        .clk        (clk),
        .aclr       (aclr),
        .step_in    (step_in),
        .up         (up),
        .load       (load),
        .load_digit (load_value[4*gi +: 4]),
        .digit      (digit),
        .step_out   (step_out)
      );

      assign count[4*gi +: 4] = digit;
      assign hex[7*gi +: 7]   = ((LZB != 0) && (gi != 0) && zero_above && (digit == 4'd0))
                                ? SEG_BLANK : seg_decode(digit);
    end
  endgenerate

  assign tick = tick_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_counter_bcd_display.sv
// Directed scoreboard bench for counter_bcd_display (DIGITS=2, PRESCALE=4), LZB=0 and LZB=1 instances.
module tb_counter_bcd_display;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        aclr;
  logic        enable;
  logic        up;
  logic        load;
  logic [7:0]  load_value;
  logic [7:0]  count, count_lzb;
  logic [13:0] hex, hex_lzb;
  logic        tick, tick_lzb;
  logic        wrap, wrap_lzb;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tick;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_cnt;
  int   m_pre;

  // Reference segment patterns written a..g, left to right.
  bit [6:0] seg_ag [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  always #5 clk = ~clk;

  counter_bcd_display #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .LZB(0)) dut (
    .clk(clk), .aclr(aclr), .enable(enable), .up(up), .load(load), .load_value(load_value),
    .count(count), .hex(hex), .tick(tick), .wrap(wrap)
  );

  counter_bcd_display #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .LZB(1)) dut_lzb (
    .clk(clk), .aclr(aclr), .enable(enable), .up(up), .load(load), .load_value(load_value),
    .count(count_lzb), .hex(hex_lzb), .tick(tick_lzb), .wrap(wrap_lzb)
  );

  function automatic logic [6:0] seg_of(input int d);
    bit   [6:0] s;
    logic [6:0] r;
    s = seg_ag[d];
    for (int k = 0; k < 7; k++) r[k] = s[6-k];
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] hex_exp(input int v, input bit lzb);
    logic [6:0] hi;
    hi = (lzb && v < 10) ? 7'b1111111 : seg_of(v / 10);
    return {hi, seg_of(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Behavioural decimal model: predicts the state after the coming clock edge.
  task automatic model_step();
    int   d0, d1;
    exp_t e;
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (load) begin
      d0    = (load_value[3:0] > 4'd9) ? 9 : int'(load_value[3:0]);
      d1    = (load_value[7:4] > 4'd9) ? 9 : int'(load_value[7:4]);
      m_cnt = d1 * 10 + d0;
      m_pre = 0;
    end else if (enable) begin
      if (m_pre == PRESCALE - 1) begin
        m_pre  = 0;
        e.tick = 1'b1;
        if (up) begin
          e.wrap = (m_cnt == 99);
          m_cnt  = (m_cnt + 1) % 100;
        end else begin
          e.wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 99) % 100;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    e.cnt = to_bcd(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("count", 32'(count), 32'(e.cnt));
    chk("tick_wrap", {30'd0, tick, wrap}, {30'd0, e.tick, e.wrap});
    chk("hex", 32'(hex), 32'(hex_exp(m_cnt, 1'b0)));
    chk("count_lzb", {22'd0, count_lzb, tick_lzb, wrap_lzb}, {22'd0, e.cnt, e.tick, e.wrap});
    chk("hex_lzb", 32'(hex_lzb), 32'(hex_exp(m_cnt, 1'b1)));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load_cycle(input logic [7:0] v);
    load       = 1'b1;
    load_value = v;
    cycle();
    load       = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs are checked before any edge.
  task automatic async_reset();
    aclr = 1'b0;
    #2;
    m_cnt = 0;
    m_pre = 0;
    chk("rst_count", 32'(count), 32'h00);
    chk("rst_tick_wrap", {30'd0, tick, wrap}, 32'd0);
    chk("rst_hex", 32'(hex), 32'(hex_exp(0, 1'b0)));
    chk("rst_hex_lzb", 32'(hex_lzb), {18'd0, 7'b1111111, seg_of(0)});
    #2;
    aclr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 8'h00;
    m_cnt = 0; m_pre = 0;
    #3;
    chk("reset_count", 32'(count), 32'h00);
    chk("reset_pulses", {30'd0, tick, wrap}, 32'd0);
    chk("reset_hex", 32'(hex), {18'd0, 7'b1000000, 7'b1000000});
    chk("reset_hex_lzb", 32'(hex_lzb), {18'd0, 7'b1111111, 7'b1000000});
    @(posedge clk);
    #1;
    aclr = 1'b1;

    // Free counting up: ten steps reach 10.
    enable = 1'b1; up = 1'b1;
    run(40);
    chk("ten_steps", 32'(count), 32'h10);
    run(4);

    // Up-wrap from 99.
    load_cycle(8'h99);
    run(4);
    chk("up_wrap", {22'd0, wrap, tick, count}, {22'd0, 1'b1, 1'b1, 8'h00});
    cycle();
    chk("wrap_one_cycle", {31'd0, wrap}, 32'd0);

    // Down-wrap from 00, then 98.
    up = 1'b0;
    run(3);
    chk("down_wrap", {22'd0, wrap, tick, count}, {22'd0, 1'b1, 1'b1, 8'h99});
    run(4);
    chk("down_98", {22'd0, wrap, tick, count}, {22'd0, 1'b0, 1'b1, 8'h98});

    // Load coinciding with a step, with a clamped digit.
    run(3);
    load_cycle(8'h3F);
    chk("load_over_step", {23'd0, tick, count}, {23'd0, 1'b0, 8'h39});
    run(3);
    chk("no_early_step", {23'd0, tick, count}, {23'd0, 1'b0, 8'h39});
    cycle();
    chk("step_after_load", {23'd0, tick, count}, {23'd0, 1'b1, 8'h38});

    // Direction change mid-prescale.
    run(2);
    up = 1'b1;
    run(2);
    chk("dir_change", 32'(count), 32'h39);

    // Clamp of upper digit, then hold with enable low at prescaler=2.
    load_cycle(8'hA3);
    chk("clamp_hi", 32'(count), 32'h93);
    run(2);
    enable = 1'b0;
    run(10);
    chk("hold_count", {23'd0, tick, count}, {23'd0, 1'b0, 8'h93});
    enable = 1'b1;
    cycle();
    chk("resume_wait", 32'(tick), 32'd0);
    cycle();
    chk("resume_step", {23'd0, tick, count}, {23'd0, 1'b1, 8'h94});

    // Leading-zero blanking patterns.
    load_cycle(8'h05);
    load_cycle(8'h50);
    load_cycle(8'h00);

    // Reset mid-prescale at 57; first step comes a full prescale period later.
    load_cycle(8'h57);
    run(2);
    async_reset();
    run(3);
    chk("post_rst_wait", {23'd0, tick, count}, {23'd0, 1'b0, 8'h00});
    cycle();
    chk("post_rst_step", {23'd0, tick, count}, {23'd0, 1'b1, 8'h01});

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_bcd_display.md
COUNTER_BCD_DISPLAY -- requirements
Module: counter_bcd_display

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits, legal range 1..8.
REQ-002 Parameter PRESCALE, default 10000000, clock cycles per count step, legal range >= 1.
REQ-003 Parameter LZB, default 0, 1 = leading-zero blanking on display outputs.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 aclr  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  1 = prescaler runs; 0 = prescaler and count hold.
REQ-007 up  input  1  1 = count up, 0 = count down; sampled at the tick cycle.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_value  input  4*DIGITS  BCD value to load, digit 0 in bits [3:0].
REQ-010 count  output  4*DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-011 hex  output  7*DIGITS  active-low segments, digit i in bits [7i+6:7i], segment a at the lowest bit of each field, g at the highest.
REQ-012 tick  output  1  registered one-cycle pulse marking each count step.
REQ-013 wrap  output  1  registered one-cycle pulse marking a full-range wrap.

Function
REQ-014 Prescaler width SHALL be max(1, clog2(PRESCALE)); it counts 0..PRESCALE-1 while enable=1 and returns to 0 after PRESCALE-1.
REQ-015 Step condition SHALL be enable=1 and prescaler=PRESCALE-1; with PRESCALE=1 every enabled cycle is a step.
REQ-016 On a step with up=1, digit 0 SHALL increment; a digit at 9 becomes 0 and carries into the next digit.
REQ-017 On a step with up=0, digit 0 SHALL decrement; a digit at 0 becomes 9 and borrows from the next digit.
REQ-018 Up-wrap: all digits 9 -> all 0; down-wrap: all 0 -> all 9; wrap=1 in the same cycle count shows the wrapped value.
REQ-019 tick SHALL be 1 in the cycle count shows the stepped value, otherwise 0.
REQ-020 load=1 SHALL take priority over a step: count <= load_value, prescaler <= 0, tick=0, wrap=0 next cycle, regardless of enable.
REQ-021 A load_value digit > 9 SHALL be loaded as 9.
REQ-022 enable=0 SHALL freeze prescaler and count; tick and wrap return to 0.
REQ-023 A change of up between steps SHALL take effect at the next step; no prescaler disturbance.
REQ-024 hex SHALL be a combinational decode of count: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100 (a..g); anything else 1111111.
REQ-025 With LZB=1, a zero digit SHALL show 1111111 when all higher digits are zero; digit 0 is never blanked.

Reset
REQ-026 aclr=0 SHALL immediately force prescaler=0, count=0, tick=0, wrap=0, without waiting for clk.
REQ-027 During reset, hex SHALL show 0000001 on every digit (LZB=0) or on digit 0 only, others 1111111 (LZB=1).
REQ-028 Reset asserted mid-prescale or mid-step SHALL discard the pending step; first step after release occurs PRESCALE enabled cycles later.

Structure
REQ-029 Shared package SHALL hold the clog2 function, the ten digit segment constants and SEG_BLANK.
REQ-030 One sub-module, bcd_digit_updown (one 4-bit digit: step-in, up, load; carry/borrow-out), SHALL be instantiated DIGITS times in a ripple chain.
REQ-031 The segment decode SHALL be a function in the package, not a separate module.

Verification (DIGITS=2, PRESCALE=4, LZB=0 unless stated)
REQ-032 Reset release, enable=1, up=1 -> tick on every 4th cycle, count 00,01,02...; 09 -> 10 on the tenth step.
REQ-033 load_value=99, load, up=1, one step -> count=00, wrap=1 and tick=1 for exactly one cycle.
REQ-034 count=00, up=0, one step -> count=99, wrap=1; next step -> 98, wrap=0.
REQ-035 load asserted in the same cycle as a step, load_value=0x3F -> count=39, tick=0, next step 4 enabled cycles later.
REQ-036 aclr pulsed low mid-prescale at count=57 -> count=00 asynchronously, hex=0000001 both digits; LZB=1 variant -> digit 1 hex=1111111.
REQ-037 enable=0 for 10 cycles at prescaler=2 -> count and prescaler hold, no tick; resume -> step after 2 more enabled cycles.
